// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, exception indices, load-op bits
// and the EXE->MEM / MEM->WB bundle layouts.
package mem_stage_pkg;

    localparam int NUM_TYPES = 16;
    localparam int PASS_W    = 90;

    localparam int EXE_MEM_BUS_WDTH = PASS_W + NUM_TYPES + 108;
    localparam int MEM_WB_BUS_WDTH  = PASS_W + NUM_TYPES + 102;

    localparam int TYPE_INT    = 0;
    localparam int TYPE_ADEF   = 1;
    localparam int TYPE_TLBR_F = 2;
    localparam int TYPE_PIF    = 3;
    localparam int TYPE_PPI_F  = 4;
    localparam int TYPE_SYS    = 5;
    localparam int TYPE_BRK    = 6;
    localparam int TYPE_INE    = 7;
    localparam int TYPE_IPE    = 8;
    localparam int TYPE_ALE    = 9;
    localparam int TYPE_ADEM   = 10;
    localparam int TYPE_TLBR_M = 11;
    localparam int TYPE_PIL    = 12;
    localparam int TYPE_PIS    = 13;
    localparam int TYPE_PME    = 14;
    localparam int TYPE_PPI_M  = 15;

    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    typedef struct packed {
        logic [PASS_W-1:0]    pass;
        logic [NUM_TYPES-1:0] exc_type;
        logic                 req_issued;
        logic [4:0]           load_op;
        logic                 gr_we;
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          alu_result;
        logic [4:0]           dest;
    } exe_mem_t;

    typedef struct packed {
        logic [PASS_W-1:0]    pass;
        logic [NUM_TYPES-1:0] exc_type;
        logic                 gr_we;
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [31:0]          final_result;
        logic [4:0]           dest;
    } mem_wb_t;

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the
// response word and sign- or zero-extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  load_op,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
    end

    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        unique case (1'b1)
            load_op[LD_B]:  result = {{24{byte_sel[7]}}, byte_sel};
            load_op[LD_BU]: result = {24'd0, byte_sel};
            load_op[LD_H]:  result = {{16{half_sel[15]}}, half_sel};
            load_op[LD_HU]: result = {16'd0, half_sel};
            default:        result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data,
// forwards to ID and drops responses orphaned by flushes/cancels.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        exe_mem_valid,
    input  logic [EXE_MEM_BUS_WDTH-1:0] exe_mem_bus,
    output logic                        mem_allowin,
    input  logic                        wb_allowin,
    output logic                        mem_wb_valid,
    output logic [MEM_WB_BUS_WDTH-1:0]  mem_wb_bus,
    input  logic                        data_sram_data_ok,
    input  logic [31:0]                 data_sram_rdata,
    input  logic                        exe_cancel_outstanding,
    input  logic                        wb_flush,
    output logic [38:0]                 mem_id_bus,
    output logic                        mem_flag
);

    exe_mem_t    mem_r;
    mem_wb_t     wb_out;
    logic        mem_valid;
    logic        ready_go;
    logic        rsp_mine;
    logic        do_leave;
    logic        is_load;
    logic        data_buf_valid;
    logic [31:0] data_buf;
    logic [31:0] load_src;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic [1:0]  drop_cnt;
    logic [2:0]  drop_sum;
    logic        inc_a;
    logic        inc_b;
    logic        dec;

    assign rsp_mine    = data_sram_data_ok & (drop_cnt == 2'd0);
    assign ready_go    = ~mem_r.req_issued | data_buf_valid | rsp_mine;
    assign mem_allowin = ~mem_valid | (ready_go & wb_allowin);
    assign mem_wb_valid = mem_valid & ready_go & ~wb_flush;
    assign do_leave    = mem_valid & ready_go & wb_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
        end else if (wb_flush) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= exe_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_r <= '0;
        end else if (exe_mem_valid & mem_allowin) begin
            mem_r <= exe_mem_bus;
        end
    end

    // Hold a response that arrived while WB was stalled.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_buf_valid <= 1'b0;
            data_buf       <= '0;
        end else if (wb_flush | do_leave) begin
            data_buf_valid <= 1'b0;
        end else if (rsp_mine & mem_valid & mem_r.req_issued & ~wb_allowin) begin
            data_buf_valid <= 1'b1;
            data_buf       <= data_sram_rdata;
        end
    end

    // Count in-flight responses that no longer have an owner.
    assign inc_a = wb_flush & mem_valid & mem_r.req_issued
                 & ~data_buf_valid & ~rsp_mine;
    assign inc_b = exe_cancel_outstanding;
    assign dec   = data_sram_data_ok & (drop_cnt != 2'd0);

    assign drop_sum = {1'b0, drop_cnt} + {2'b0, inc_a}
                    + {2'b0, inc_b} - {2'b0, dec};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt <= 2'd0;
        end else begin
            drop_cnt <= drop_sum[2] ? 2'd3 : drop_sum[1:0];
        end
    end

    assign load_src = data_buf_valid ? data_buf : data_sram_rdata;
    assign is_load  = |mem_r.load_op;

    mem_load_align u_align (
        .rdata   (load_src),
        .addr    (mem_r.alu_result[1:0]),
        .load_op (mem_r.load_op),
        .result  (load_data)
    );

    // A faulting load never issued, so it keeps its address for badvaddr.
    assign final_result = (is_load & mem_r.req_issued) ? load_data
                                                       : mem_r.alu_result;

    always_comb begin
        wb_out              = '0;
        wb_out.pass         = mem_r.pass;
        wb_out.exc_type     = mem_r.exc_type;
        wb_out.gr_we        = mem_r.gr_we;
        wb_out.pc           = mem_r.pc;
        wb_out.inst         = mem_r.inst;
        wb_out.final_result = final_result;
        wb_out.dest         = mem_r.dest;
    end

    assign mem_wb_bus = wb_out;

    assign mem_id_bus = {mem_valid & mem_r.gr_we,
                         mem_r.dest,
                         final_result,
                         mem_valid & is_load & ~ready_go};

    assign mem_flag = mem_valid & (|mem_r.exc_type
                                   | mem_r.pass[0]
                                   | mem_r.pass[PASS_W-1]);

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage with a transaction-level
// reference for load extraction and response dropping.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       resetn;
    logic                       exe_mem_valid;
    exe_mem_t                   ebus;
    logic                       mem_allowin;
    logic                       wb_allowin;
    logic                       mem_wb_valid;
    logic [MEM_WB_BUS_WDTH-1:0] mem_wb_bus;
    mem_wb_t                    wbus;
    logic                       data_ok;
    logic [31:0]                rdata;
    logic                       cancel;
    logic                       wb_flush;
    logic [38:0]                mem_id_bus;
    logic                       mem_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign wbus = mem_wb_bus;

    mem_stage dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .exe_mem_valid          (exe_mem_valid),
        .exe_mem_bus            (ebus),
        .mem_allowin            (mem_allowin),
        .wb_allowin             (wb_allowin),
        .mem_wb_valid           (mem_wb_valid),
        .mem_wb_bus             (mem_wb_bus),
        .data_sram_data_ok      (data_ok),
        .data_sram_rdata        (rdata),
        .exe_cancel_outstanding (cancel),
        .wb_flush               (wb_flush),
        .mem_id_bus             (mem_id_bus),
        .mem_flag               (mem_flag)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    // kind: 0 alu, 1 ld_b, 2 ld_h, 3 ld_w, 4 ld_bu, 5 ld_hu, 6 store
    function automatic logic [4:0] kind_lop(input int kind);
        logic [4:0] l;
        l = '0;
        case (kind)
            1: l[LD_B] = 1'b1;
            2: l[LD_H] = 1'b1;
            3: l[LD_W] = 1'b1;
            4: l[LD_BU] = 1'b1;
            5: l[LD_HU] = 1'b1;
            default: l = '0;
        endcase
        return l;
    endfunction

    function automatic logic [31:0] ref_result(input int kind,
                                               input logic [31:0] alu,
                                               input logic [31:0] rd);
        longint unsigned v;
        int unsigned off;
        off = alu % 4;
        case (kind)
            1, 4: begin
                v = (rd >> (8 * off)) % 256;
                if (kind == 1 && v >= 128) v = v + 64'hFFFF_FF00;
            end
            2, 5: begin
                v = (rd >> (16 * (off / 2))) % 65536;
                if (kind == 2 && v >= 32768) v = v + 64'hFFFF_0000;
            end
            3: v = rd;
            default: v = alu;
        endcase
        return v[31:0];
    endfunction

    function automatic exe_mem_t mk(input logic [4:0] lop, input logic req,
                                    input logic [31:0] alu,
                                    input logic [4:0] dst);
        exe_mem_t b;
        b            = '0;
        b.load_op    = lop;
        b.req_issued = req;
        b.alu_result = alu;
        b.dest       = dst;
        b.gr_we      = (lop != 5'd0) | !req;
        b.pc         = $urandom;
        b.inst       = $urandom;
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          kind, lat, stall, junk;
    logic        issued, got, fire, exp_v, done;
    logic [31:0] a, rd, pa;
    logic [4:0]  pd;

    initial begin
        resetn = 1'b0;
        exe_mem_valid = 1'b0;
        ebus = '0;
        wb_allowin = 1'b1;
        data_ok = 1'b0;
        rdata = '0;
        cancel = 1'b0;
        wb_flush = 1'b0;
        repeat (3) cyc();

        look();
        chk("rst_wb_valid", mem_wb_valid, 0);
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_flag", mem_flag, 0);
        chk("rst_id_bus", mem_id_bus, 0);
        chk("rst_wb_result", wbus.final_result, 0);
        chk("rst_wb_pc", wbus.pc, 0);
        chk("rst_drop", dut.drop_cnt, 0);
        resetn = 1'b1;
        cyc();

        // ld_b from byte 3
        ebus = mk(kind_lop(1), 1'b1, 32'h0000_1003, 5'd7);
        exe_mem_valid = 1'b1;
        look();
        chk("t1_allowin_empty", mem_allowin, 1);
        cyc();
        exe_mem_valid = 1'b0;
        look();
        chk("t1_wait_valid", mem_wb_valid, 0);
        chk("t1_wait_allowin", mem_allowin, 0);
        chk("t1_pending", mem_id_bus[0], 1);
        cyc();
        data_ok = 1'b1;
        rdata = 32'h8011_2233;
        look();
        chk("t1_valid", mem_wb_valid, 1);
        chk("t1_result", wbus.final_result, 32'hFFFF_FF80);
        chk("t1_dest", wbus.dest, 7);
        chk("t1_no_pending", mem_id_bus[0], 0);
        cyc();
        data_ok = 1'b0;
        look();
        chk("t1_drained", mem_wb_valid, 0);

        // ld_hu with response arriving while WB stalls
        ebus = mk(kind_lop(5), 1'b1, 32'h0000_2002, 5'd9);
        exe_mem_valid = 1'b1;
        wb_allowin = 1'b0;
        cyc();
        exe_mem_valid = 1'b0;
        data_ok = 1'b1;
        rdata = 32'hBEEF_1234;
        look();
        chk("t2_rsp_valid", mem_wb_valid, 1);
        chk("t2_rsp_result", wbus.final_result, 32'h0000_BEEF);
        cyc();
        data_ok = 1'b0;
        rdata = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            look();
            chk("t2_held_valid", mem_wb_valid, 1);
            chk("t2_held_result", wbus.final_result, 32'h0000_BEEF);
            cyc();
        end
        wb_allowin = 1'b1;
        look();
        chk("t2_release_valid", mem_wb_valid, 1);
        chk("t2_release_result", wbus.final_result, 32'h0000_BEEF);
        cyc();
        look();
        chk("t2_one_accept", mem_wb_valid, 0);

        // flush while a load waits, orphaning its response
        ebus = mk(kind_lop(3), 1'b1, 32'h0000_3000, 5'd3);
        exe_mem_valid = 1'b1;
        cyc();
        exe_mem_valid = 1'b0;
        look();
        chk("t3_wait_valid", mem_wb_valid, 0);
        cyc();
        wb_flush = 1'b1;
        look();
        chk("t3_flush_valid", mem_wb_valid, 0);
        cyc();
        wb_flush = 1'b0;
        look();
        chk("t3_allowin", mem_allowin, 1);
        chk("t3_rf_we", mem_id_bus[38], 0);
        chk("t3_drop", dut.drop_cnt, 1);
        ebus = mk(kind_lop(3), 1'b1, 32'h0000_3004, 5'd4);
        exe_mem_valid = 1'b1;
        cyc();
        exe_mem_valid = 1'b0;
        data_ok = 1'b1;
        rdata = 32'hDEAD_0000;
        look();
        chk("t3_stale_valid", mem_wb_valid, 0);
        chk("t3_stale_pending", mem_id_bus[0], 1);
        cyc();
        rdata = 32'h1234_5678;
        look();
        chk("t3_drop_clear", dut.drop_cnt, 0);
        chk("t3_own_valid", mem_wb_valid, 1);
        chk("t3_own_result", wbus.final_result, 32'h1234_5678);
        cyc();
        data_ok = 1'b0;

        // cancel coinciding with a dropped response
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        look();
        chk("t4_drop_one", dut.drop_cnt, 1);
        cancel = 1'b1;
        data_ok = 1'b1;
        rdata = $urandom;
        cyc();
        cancel = 1'b0;
        data_ok = 1'b0;
        look();
        chk("t4_drop_hold", dut.drop_cnt, 1);
        ebus = mk(kind_lop(3), 1'b1, 32'h0000_4000, 5'd5);
        exe_mem_valid = 1'b1;
        cyc();
        exe_mem_valid = 1'b0;
        data_ok = 1'b1;
        rdata = 32'h1111_1111;
        look();
        chk("t4_first_dropped", mem_wb_valid, 0);
        cyc();
        rdata = 32'h2222_2222;
        look();
        chk("t4_second_valid", mem_wb_valid, 1);
        chk("t4_second_result", wbus.final_result, 32'h2222_2222);
        chk("t4_drop_zero", dut.drop_cnt, 0);
        cyc();
        data_ok = 1'b0;

        // exception passes straight through
        ebus = mk(5'd0, 1'b0, 32'h0000_1001, 5'd6);
        ebus.exc_type[TYPE_ALE] = 1'b1;
        exe_mem_valid = 1'b1;
        cyc();
        exe_mem_valid = 1'b0;
        look();
        chk("t5_valid", mem_wb_valid, 1);
        chk("t5_flag", mem_flag, 1);
        chk("t5_result", wbus.final_result, 32'h0000_1001);
        chk("t5_exc", wbus.exc_type, 64'h200);
        cyc();
        look();
        chk("t5_flag_clear", mem_flag, 0);
        for (int i = 0; i < 2; i++) begin
            ebus = mk(5'd0, 1'b0, $urandom, 5'd2);
            if (i == 0) ebus.pass[0] = 1'b1;
            else ebus.pass[PASS_W-1] = 1'b1;
            exe_mem_valid = 1'b1;
            cyc();
            exe_mem_valid = 1'b0;
            look();
            chk("t5_pass_flag", mem_flag, 1);
            cyc();
        end

        // back-to-back ALU ops
        pa = '0;
        pd = '0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            ebus = mk(5'd0, 1'b0, a, 5'(i + 10));
            exe_mem_valid = (i < 4);
            if (i > 0) begin
                look();
                chk("t6_valid", mem_wb_valid, 1);
                chk("t6_allowin", mem_allowin, 1);
                chk("t6_id_bus", mem_id_bus, {1'b1, pd, pa, 1'b0});
            end
            cyc();
            pa = a;
            pd = 5'(i + 10);
        end
        exe_mem_valid = 1'b0;
        look();
        chk("t6_drained", mem_wb_valid, 0);

        // randomized single-instruction transactions
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 6);
            issued = (kind != 0);
            a = $urandom;
            if (kind == 2 || kind == 5) a[0] = 1'b0;
            if (kind == 3 || kind == 6) a[1:0] = 2'b00;
            rd = $urandom;
            lat = $urandom_range(0, 3);
            stall = $urandom_range(0, 3);
            junk = issued ? $urandom_range(0, 2) : 0;
            for (int j = 0; j < junk; j++) begin
                cancel = 1'b1;
                cyc();
            end
            cancel = 1'b0;
            look();
            chk("rnd_drop", dut.drop_cnt, junk);
            ebus = mk(kind_lop(kind), issued, a, 5'($urandom));
            exe_mem_valid = 1'b1;
            wb_allowin = 1'($urandom_range(0, 1));
            look();
            chk("rnd_entry_allowin", mem_allowin, 1);
            cyc();
            exe_mem_valid = 1'b0;
            got = !issued;
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                fire = issued && !got && c >= lat;
                data_ok = fire;
                rdata = $urandom;
                exp_v = got;
                if (fire) begin
                    if (junk > 0) begin
                        junk--;
                    end else begin
                        exp_v = 1'b1;
                        got = 1'b1;
                        rdata = rd;
                    end
                end
                wb_allowin = (c >= stall);
                look();
                chk("rnd_valid", mem_wb_valid, exp_v);
                chk("rnd_pending", mem_id_bus[0],
                    (kind >= 1 && kind <= 5) && !exp_v);
                if (exp_v) begin
                    chk("rnd_result", wbus.final_result, ref_result(kind, a, rd));
                end
                if (exp_v && wb_allowin) done = 1'b1;
                cyc();
            end
            data_ok = 1'b0;
            chk("rnd_completed", done, 1);
        end

        // reset while a load waits and a cancel is counted
        wb_allowin = 1'b1;
        cancel = 1'b1;
        ebus = mk(kind_lop(3), 1'b1, 32'h0000_5000, 5'd8);
        exe_mem_valid = 1'b1;
        cyc();
        cancel = 1'b0;
        exe_mem_valid = 1'b0;
        look();
        chk("rst2_drop_before", dut.drop_cnt, 1);
        chk("rst2_pending", mem_id_bus[0], 1);
        resetn = 1'b0;
        cyc();
        look();
        chk("rst2_drop", dut.drop_cnt, 0);
        chk("rst2_wb_valid", mem_wb_valid, 0);
        chk("rst2_id_bus", mem_id_bus, 0);
        resetn = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
